risc_fsm_core: RTL and testbench
================================

RISC_FSM_CORE -- requirements
Module: risc_fsm_core

Interface
REQ-001 Parameter DATA_W, 8, register/ALU datapath width in bits (legal 8..32).
REQ-002 Parameter PC_W, 8, program counter and instruction address width (legal 4..16).
REQ-003 Port clk input 1: single clock; every state element updates on its rising edge.
REQ-004 Port rst input 1: reset, asynchronous, active-high.
REQ-005 Port imem_addr output PC_W: instruction fetch address, always equal to the PC.
REQ-006 Port imem_rdata input 16: instruction word, sampled only in FETCH when imem_ready=1.
REQ-007 Port imem_ready input 1: instruction memory handshake; FETCH stalls while 0.
REQ-008 Port current_instruction output 16: instruction register (IR).
REQ-009 Port program_counter_out output PC_W: current PC.
REQ-010 Port state_out output 3: FSM state (FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4).
REQ-011 Port halted output 1: high while in HALT.
REQ-012 Port zero_flag / carry_flag output 1 each: ALU status flags.
REQ-013 Port dbg_sel input 3 / dbg_data output DATA_W: combinational read of register dbg_sel.

Function
REQ-014 Eight registers r0..r7 of DATA_W bits; encoding op[15:12], rd[11:9], rs1[8:6], rs2[5:3], imm8[7:0], off6[5:0].
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT rd=~rs1, 5 LDI rd=zero-extended imm8 (truncated if DATA_W<8 never applies), 6 BEQZ rs1,off6, 7 JMP imm8, 8 MUL (see REQ-031), F HALT, 9..E NOP.
REQ-016 FETCH: stay while imem_ready=0; on imem_ready=1 latch imem_rdata into IR, go DECODE.
REQ-017 DECODE: latch operands rs1/rs2 values into operand registers, go EXECUTE; HALT opcode goes HALT instead.
REQ-018 EXECUTE: compute and latch ALU result and next PC, go WRITEBACK.
REQ-019 WRITEBACK: write rd if op writes a register, load PC with next PC, go FETCH.
REQ-020 Non-stalled instruction latency exactly 4 cycles; each FETCH stall cycle adds one.
REQ-021 ADD/SUB modulo 2^DATA_W; carry_flag = carry-out (ADD) or borrow (SUB); AND/OR/NOT/MUL clear carry.
REQ-022 zero_flag = (result==0); flags update in WRITEBACK only for ALU ops (ADD,SUB,AND,OR,NOT,MUL); LDI, BEQZ, JMP, NOP leave flags unchanged.
REQ-023 Next PC: PC+1 default; BEQZ with r[rs1]==0: PC+1+sign-extended off6; JMP: imm8 zero-extended/truncated to PC_W; all PC arithmetic wraps modulo 2^PC_W.
REQ-024 rd==rs1 or rd==rs2 is legal; operands are those read in DECODE.
REQ-025 HALT: PC, IR, registers, flags frozen; imem_ready ignored; exit only via rst.
REQ-026 dbg_sel reads reflect a WRITEBACK write from the following cycle.

Reset
REQ-027 rst asserted at any time, including mid-EXECUTE or during a FETCH stall, aborts the instruction with no register or flag write.
REQ-028 Reset values: PC=0, IR=0, r0..r7=0, operand/result registers=0, flags=0, state=FETCH, halted=0.
REQ-029 First FETCH begins on the first rising clk after rst deasserts.
REQ-030 No output shows X after reset.

Configuration
REQ-031 Macro RISC_FSM_MUL_EN defined: opcode 8 is MUL, rd = low DATA_W bits of r[rs1]*r[rs2].
REQ-032 Macro RISC_FSM_MUL_EN undefined: opcode 8 is NOP (no write, flags unchanged, PC+1) and no multiplier is synthesised.

Verification
REQ-033 DATA_W=8: LDI r0,0xAA; LDI r1,0x0C; ADD r0,r0,r1 -> r0=0xB6, zero=0, carry=0, completed at cycle 12 after reset release.
REQ-034 LDI r2,0xFF; LDI r3,0x01; ADD r2,r2,r3 -> r2=0x00, zero=1, carry=1; then SUB r2,r2,r3 -> r2=0xFF, carry=1.
REQ-035 r4=0 then BEQZ r4,off6=0x3E (-2) at PC=5 -> PC=4; r4=1 -> PC=6; JMP 0x20 -> PC=0x20; PC=0xFF+1 wraps to 0x00.
REQ-036 imem_ready held 0 for 3 cycles in FETCH -> state stays 0, IR unchanged; instruction completes in 7 cycles.
REQ-037 HALT at PC=3 -> halted=1, state=4, PC stays 3 for 20 cycles; rst pulse mid-EXECUTE of ADD -> registers 0, PC=0, state=0.
REQ-038 MUL r5,r0,r1 with r0=0x0C, r1=0x15: macro defined -> r5=0xFC; undefined -> r5 unchanged, PC+1.

Source files
------------

// File: rtl/risc_fsm_core.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK core with 8 registers and 16-bit instructions.
// Define RISC_FSM_MUL_EN to make opcode 8 a multiply; otherwise opcode 8 is a NOP.
module risc_fsm_core #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_ready,
   output logic [15:0]       current_instruction,
   output logic [PC_W-1:0]   program_counter_out,
   output logic [2:0]        state_out,
   output logic              halted,
   output logic              zero_flag,
   output logic              carry_flag,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      WRITEBACK = 3'd3,
      HALT      = 3'd4
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_NOT  = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_BEQZ = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
`ifdef RISC_FSM_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'h8;
`endif
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t            state, state_nx;
   logic [PC_W-1:0]   pc, next_pc, pc_calc;
   logic [15:0]       ir;
   logic [DATA_W-1:0] regs [8];
   logic [DATA_W-1:0] op_a, op_b, res_q;
   logic              carry_q, zf, cf;
   logic [DATA_W:0]   alu;
   logic              wr_en, flag_en;
   logic [3:0]        op;
   logic [2:0]        rd, rs1, rs2;

   assign op  = ir[15:12];
   assign rd  = ir[11:9];
   assign rs1 = ir[8:6];
   assign rs2 = ir[5:3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         FETCH:     if (imem_ready) state_nx = DECODE;
         DECODE:    state_nx = (op == OP_HALT) ? HALT : EXECUTE;
         EXECUTE:   state_nx = WRITEBACK;
         WRITEBACK: state_nx = FETCH;
         HALT:      state_nx = HALT;
         default:   state_nx = FETCH;
      endcase
   end

   // ALU and next-PC; the extra alu MSB carries carry-out (ADD) or borrow (SUB).
   always_comb begin
      alu     = '0;
      pc_calc = pc + PC_W'(1);
      wr_en   = 1'b0;
      flag_en = 1'b0;
      case (op)
         OP_ADD: begin alu = {1'b0, op_a} + {1'b0, op_b}; wr_en = 1'b1; flag_en = 1'b1; end
         OP_SUB: begin alu = {1'b0, op_a} - {1'b0, op_b}; wr_en = 1'b1; flag_en = 1'b1; end
         OP_AND: begin alu = {1'b0, op_a & op_b};         wr_en = 1'b1; flag_en = 1'b1; end
         OP_OR:  begin alu = {1'b0, op_a | op_b};         wr_en = 1'b1; flag_en = 1'b1; end
         OP_NOT: begin alu = {1'b0, ~op_a};               wr_en = 1'b1; flag_en = 1'b1; end
         OP_LDI: begin alu = {{(DATA_W-7){1'b0}}, ir[7:0]}; wr_en = 1'b1; end
         OP_BEQZ: begin
            if (op_a == '0) pc_calc = pc + PC_W'(1) + PC_W'({{10{ir[5]}}, ir[5:0]});
         end
         OP_JMP: pc_calc = PC_W'(ir[7:0]);
`ifdef RISC_FSM_MUL_EN
         // Product is self-determined at DATA_W bits: only the low half is built.
         OP_MUL: begin alu = {1'b0, op_a * op_b}; wr_en = 1'b1; flag_en = 1'b1; end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= '0;
         ir      <= '0;
         op_a    <= '0;
         op_b    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         next_pc <= '0;
         zf      <= 1'b0;
         cf      <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         case (state)
            FETCH:  if (imem_ready) ir <= imem_rdata;
            DECODE: begin
               op_a <= regs[rs1];
               op_b <= regs[rs2];
            end
            EXECUTE: begin
               res_q   <= alu[DATA_W-1:0];
               carry_q <= alu[DATA_W];
               next_pc <= pc_calc;
            end
            WRITEBACK: begin
               if (wr_en) regs[rd] <= res_q;
               if (flag_en) begin
                  zf <= (res_q == '0);
                  cf <= carry_q;
               end
               pc <= next_pc;
            end
            default: ;
         endcase
      end
   end

   assign imem_addr           = pc;
   assign program_counter_out = pc;
   assign current_instruction = ir;
   assign state_out           = state;
   assign halted              = (state == HALT);
   assign zero_flag           = zf;
   assign carry_flag          = cf;
   assign dbg_data            = regs[dbg_sel];

endmodule

// File: tb/tb_risc_fsm_core.sv
// Directed bench for risc_fsm_core: instruction-level reference model checked every cycle,
// plus literal expectations for the reference programs.
`timescale 1ns/100ps
module tb_risc_fsm_core;
   localparam int DATA_W = 8;
   localparam int PC_W   = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              imem_ready = 1'b1;
   logic [2:0]        dbg_sel = 3'd0;
   logic [PC_W-1:0]   imem_addr;
   logic [15:0]       imem_rdata;
   logic [15:0]       current_instruction;
   logic [PC_W-1:0]   program_counter_out;
   logic [2:0]        state_out;
   logic              halted, zero_flag, carry_flag;
   logic [DATA_W-1:0] dbg_data;

   logic [15:0]       imem [256];
   logic [DATA_W-1:0] dut_regs [8];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Reference model: architectural state plus cycles spent in the current instruction.
   int          m_reg [8];
   int          m_pc = 0;
   int          m_phase = 0;
   bit          m_halt = 1'b0, m_z = 1'b0, m_c = 1'b0;
   logic [15:0] m_ir = 16'h0;

   assign imem_rdata = imem[imem_addr];

   risc_fsm_core #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .current_instruction(current_instruction), .program_counter_out(program_counter_out),
      .state_out(state_out), .halted(halted),
      .zero_flag(zero_flag), .carry_flag(carry_flag),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   initial forever #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
      m_pc = 0; m_phase = 0; m_halt = 1'b0; m_z = 1'b0; m_c = 1'b0; m_ir = 16'h0;
   endtask

   task automatic model_exec(input logic [15:0] ins);
      int a, b, res, pcn, off, cy;
      bit wr, fl;
      a   = m_reg[ins[8:6]];
      b   = m_reg[ins[5:3]];
      pcn = (m_pc + 1) % 256;
      res = 0; cy = 0; wr = 1'b1; fl = 1'b1;
      case (int'(ins[15:12]))
         0: begin res = a + b; cy = (res > 255) ? 1 : 0; end
         1: begin res = a - b; cy = (a < b) ? 1 : 0; end
         2: res = a & b;
         3: res = a | b;
         4: res = ~a;
         5: begin res = int'(ins[7:0]); fl = 1'b0; end
         6: begin
            wr = 1'b0; fl = 1'b0;
            off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
            if (a == 0) pcn = (m_pc + 1 + off + 256) % 256;
         end
         7: begin wr = 1'b0; fl = 1'b0; pcn = int'(ins[7:0]); end
`ifdef RISC_FSM_MUL_EN
         8: res = a * b;
`endif
         default: begin wr = 1'b0; fl = 1'b0; end
      endcase
      res = res & 255;
      if (wr) m_reg[ins[11:9]] = res;
      if (fl) begin m_z = (res == 0); m_c = (cy != 0); end
      m_pc = pcn;
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else if (!m_halt) begin
         case (m_phase)
            0: if (imem_ready) begin m_ir = imem[m_pc]; m_phase = 1; end
            1: if (m_ir[15:12] == 4'hF) m_halt = 1'b1; else m_phase = 2;
            2: m_phase = 3;
            default: begin model_exec(m_ir); m_phase = 0; end
         endcase
      end
   end

   // Every falling edge: sweep the register file through dbg_sel, then compare all outputs.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         dbg_sel = 3'(i);
         #1;
         dut_regs[i] = dbg_data;
      end
      if (chk_en) begin
         check("state", 32'(state_out), 32'(m_halt ? 4 : m_phase));
         check("halted", 32'(halted), 32'(m_halt));
         check("pc", 32'(program_counter_out), 32'(m_pc));
         check("imem_addr", 32'(imem_addr), 32'(m_pc));
         check("ir", 32'(current_instruction), 32'(m_ir));
         check("zero", 32'(zero_flag), 32'(m_z));
         check("carry", 32'(carry_flag), 32'(m_c));
         for (int i = 0; i < 8; i++) check($sformatf("r%0d", i), 32'(dut_regs[i]), 32'(m_reg[i]));
      end
   end

   task automatic after_edges(input int n);
      repeat (n) @(posedge clk);
      #19;
   endtask

   task automatic load_begin();
      rst = 1'b1;
      imem_ready = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = 16'h9000;
   endtask

   task automatic load_s1();
      load_begin();
      imem[0] = 16'h50AA;  // LDI r0,0xAA
      imem[1] = 16'h520C;  // LDI r1,0x0C
      imem[2] = 16'h0008;  // ADD r0,r0,r1
      imem[3] = 16'hF000;  // HALT
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 16'h9000;
      after_edges(2);
      chk_en = 1'b1;
      check("reset_pc", 32'(program_counter_out), 32'h0);
      check("reset_state", 32'(state_out), 32'h0);

      // Basic ADD, then HALT with imem_ready toggling
      load_s1();
      after_edges(1); rst = 1'b0;
      after_edges(12);
      check("s1_r0", 32'(dut_regs[0]), 32'hB6);
      check("s1_model_r0", 32'(m_reg[0]), 32'hB6);
      check("s1_zero", 32'(zero_flag), 32'h0);
      check("s1_carry", 32'(carry_flag), 32'h0);
      after_edges(2);
      check("halt_flag", 32'(halted), 32'h1);
      check("halt_state", 32'(state_out), 32'h4);
      imem_ready = 1'b0;
      after_edges(10);
      imem_ready = 1'b1;
      after_edges(10);
      check("halt_pc", 32'(program_counter_out), 32'h3);
      check("halt_state2", 32'(state_out), 32'h4);

      // Carry, zero, borrow and logic ops
      load_begin();
      imem[0] = 16'h54FF;  // LDI r2,0xFF
      imem[1] = 16'h5601;  // LDI r3,0x01
      imem[2] = 16'h0498;  // ADD r2,r2,r3
      imem[3] = 16'h1498;  // SUB r2,r2,r3
      imem[4] = 16'h2C98;  // AND r6,r2,r3
      imem[5] = 16'h4A80;  // NOT r5,r2
      imem[6] = 16'hF000;
      after_edges(1); rst = 1'b0;
      after_edges(12);
      check("add_wrap_r2", 32'(dut_regs[2]), 32'h00);
      check("add_zero", 32'(zero_flag), 32'h1);
      check("add_carry", 32'(carry_flag), 32'h1);
      after_edges(4);
      check("sub_r2", 32'(dut_regs[2]), 32'hFF);
      check("sub_borrow", 32'(carry_flag), 32'h1);
      check("sub_zero", 32'(zero_flag), 32'h0);
      after_edges(4);
      check("and_r6", 32'(dut_regs[6]), 32'h01);
      check("and_carry", 32'(carry_flag), 32'h0);
      after_edges(4);
      check("not_r5", 32'(dut_regs[5]), 32'h00);
      check("not_zero", 32'(zero_flag), 32'h1);

      // Branches, jumps and PC wrap
      load_begin();
      imem[0]    = 16'h7005;  // JMP 5
      imem[4]    = 16'h5801;  // LDI r4,1
      imem[5]    = 16'h613E;  // BEQZ r4,-2
      imem[6]    = 16'h7020;  // JMP 0x20
      imem[8'h20] = 16'h70FF; // JMP 0xFF
      after_edges(1); rst = 1'b0;
      after_edges(8);
      check("beqz_taken_pc", 32'(program_counter_out), 32'h04);
      check("model_beqz_pc", 32'(m_pc), 32'h04);
      after_edges(8);
      check("beqz_not_taken_pc", 32'(program_counter_out), 32'h06);
      after_edges(4);
      check("jmp_pc", 32'(program_counter_out), 32'h20);
      after_edges(8);
      check("pc_wrap", 32'(program_counter_out), 32'h00);
      check("br_flags", 32'({zero_flag, carry_flag}), 32'h0);

      // Fetch stall
      load_s1();
      imem_ready = 1'b0;
      after_edges(1); rst = 1'b0;
      after_edges(3);
      check("stall_state", 32'(state_out), 32'h0);
      check("stall_ir", 32'(current_instruction), 32'h0);
      imem_ready = 1'b1;
      after_edges(4);
      check("stall_r0", 32'(dut_regs[0]), 32'hAA);
      check("stall_pc", 32'(program_counter_out), 32'h1);

      // Reset mid-EXECUTE of ADD, then recovery
      load_s1();
      after_edges(1); rst = 1'b0;
      after_edges(10);
      check("mid_exec_state", 32'(state_out), 32'h2);
      check("pre_rst_r0", 32'(dut_regs[0]), 32'hAA);
      rst = 1'b1;
      #1;
      check("async_rst_state", 32'(state_out), 32'h0);
      check("async_rst_pc", 32'(program_counter_out), 32'h0);
      after_edges(1);
      check("rst_r0", 32'(dut_regs[0]), 32'h00);
      check("rst_r1", 32'(dut_regs[1]), 32'h00);
      rst = 1'b0;
      after_edges(12);
      check("recover_r0", 32'(dut_regs[0]), 32'hB6);

      // Opcode 8
      load_begin();
      imem[0] = 16'h500C;  // LDI r0,0x0C
      imem[1] = 16'h5215;  // LDI r1,0x15
      imem[2] = 16'h8A08;  // MUL r5,r0,r1
      imem[3] = 16'hF000;
      after_edges(1); rst = 1'b0;
      after_edges(12);
`ifdef RISC_FSM_MUL_EN
      check("mul_r5", 32'(dut_regs[5]), 32'hFC);
`else
      check("mul_nop_r5", 32'(dut_regs[5]), 32'h00);
`endif
      check("mul_pc", 32'(program_counter_out), 32'h3);
      check("mul_flags", 32'({zero_flag, carry_flag}), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
